// File: rtl/accel_bus_master.sv
// Host-side initiator for the lane-detection accelerator bus: packs RGB pixels into
// 32-bit writes, polls the output-valid register, then streams the lane map back out.
module accel_bus_master #(
  parameter int IN_WIDTH       = 512,
  parameter int IN_HEIGHT      = 256,
  parameter int OUT_WIDTH      = 64,
  parameter int OUT_HEIGHT     = 32,
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int OFFSET_OUTPUT  = 393216,
  parameter int OFFSET_OVALID  = 395264,
  parameter int OFFSET_RESET   = 395272,
  parameter int POLL_INTERVAL  = 16,
  parameter int TIMEOUT_POLLS  = 65535
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      soft_reset_en,
  input  logic [23:0]               pix_data,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  output logic [31:0]               out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [31:0]               axi_wr_data,
  output logic [AXI_ADDR_WIDTH-1:0] axi_wr_addr,
  output logic                      axi_wr_en,
  output logic [3:0]                axi_wr_strobe,
  output logic [AXI_ADDR_WIDTH-1:0] axi_rd_addr,
  output logic                      axi_rd_en,
  input  logic [31:0]               axi_rd_data
);

  localparam int NPIX   = IN_WIDTH * IN_HEIGHT;
  localparam int NOUT   = OUT_WIDTH * OUT_HEIGHT / 4;
  localparam int PIX_W  = $clog2(NPIX + 1);
  localparam int OUT_W  = $clog2(NOUT + 1);
  localparam int POLL_W = $clog2(TIMEOUT_POLLS + 1);
  localparam int WAIT_W = $clog2(((POLL_INTERVAL > 16) ? POLL_INTERVAL : 16) + 1);
  localparam int WIDX_W = AXI_ADDR_WIDTH - 2;

  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_OUTPUT = AXI_ADDR_WIDTH'(OFFSET_OUTPUT);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_OVALID = AXI_ADDR_WIDTH'(OFFSET_OVALID);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_RESET  = AXI_ADDR_WIDTH'(OFFSET_RESET);
  localparam logic [WAIT_W-1:0]         SRST_WAIT   = WAIT_W'(16);
  localparam logic [WAIT_W-1:0]         POLL_LAST   = WAIT_W'(POLL_INTERVAL - 1);
  localparam logic [POLL_W-1:0]         POLL_MAX    = POLL_W'(TIMEOUT_POLLS - 1);
  localparam logic [OUT_W-1:0]          NOUT_C      = OUT_W'(NOUT);
  localparam logic [OUT_W-1:0]          NOUT_LAST   = OUT_W'(NOUT - 1);
  localparam logic [PIX_W-1:0]          NPIX_C      = PIX_W'(NPIX);

  typedef enum logic [2:0] {S_IDLE, S_SRST, S_LOAD, S_POLL, S_READ, S_DONE} state_e;

  state_e                    state_q, state_d;
  logic                      error_q, error_d;
  logic [47:0]               buf_q, buf_d;
  logic [2:0]                h_q, h_d;
  logic [PIX_W-1:0]          pix_left_q, pix_left_d;
  logic [WIDX_W-1:0]         word_idx_q, word_idx_d;
  logic [WAIT_W-1:0]         wait_q, wait_d;
  logic [POLL_W-1:0]         poll_q, poll_d;
  logic                      sample_q, sample_d;
  logic [OUT_W-1:0]          rd_idx_q, rd_idx_d;
  logic [OUT_W-1:0]          acc_q, acc_d;
  logic [31:0]               out_data_q, out_data_d;
  logic                      out_valid_q, out_valid_d;
  logic                      wr_en_q, wr_en_d;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]               wr_data_q, wr_data_d;
  logic [3:0]                wr_strobe_q, wr_strobe_d;
  logic                      rd_en_q, rd_en_d;
  logic [AXI_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

  logic        w_now;
  logic [2:0]  h_rem;
  logic [47:0] buf_rem;
  logic        accept;

  // A full word leaves the buffer this cycle whenever four bytes are held.
  assign w_now     = (h_q >= 3'd4);
  assign h_rem     = w_now ? (h_q - 3'd4) : h_q;
  assign buf_rem   = w_now ? {32'd0, buf_q[47:32]} : buf_q;
  assign pix_ready = (state_q == S_LOAD) && (h_rem < 3'd4) && (pix_left_q != '0);
  assign accept    = pix_valid && pix_ready;

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign error         = error_q;
  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign axi_wr_en     = wr_en_q;
  assign axi_wr_addr   = wr_addr_q;
  assign axi_wr_data   = wr_data_q;
  assign axi_wr_strobe = wr_strobe_q;
  assign axi_rd_en     = rd_en_q;
  assign axi_rd_addr   = rd_addr_q;

  always_comb begin
    state_d     = state_q;
    error_d     = error_q;
    buf_d       = buf_q;
    h_d         = h_q;
    pix_left_d  = pix_left_q;
    word_idx_d  = word_idx_q;
    wait_d      = wait_q;
    poll_d      = poll_q;
    sample_d    = rd_en_q;
    rd_idx_d    = rd_idx_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_strobe_d = wr_strobe_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          error_d    = 1'b0;
          buf_d      = '0;
          h_d        = '0;
          pix_left_d = NPIX_C;
          word_idx_d = '0;
          wait_d     = '0;
          poll_d     = '0;
          rd_idx_d   = '0;
          acc_d      = '0;
          if (soft_reset_en) begin
            state_d     = S_SRST;
            wr_en_d     = 1'b1;
            wr_addr_d   = ADDR_RESET;
            wr_data_d   = 32'd1;
            wr_strobe_d = 4'h1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_SRST: begin
        if (wait_q == SRST_WAIT) state_d = S_LOAD;
        else                     wait_d  = wait_q + WAIT_W'(1);
      end
      S_LOAD: begin
        if (w_now) begin
          wr_en_d     = 1'b1;
          wr_addr_d   = {word_idx_q, 2'b00};
          wr_data_d   = buf_q[31:0];
          wr_strobe_d = 4'hF;
          word_idx_d  = word_idx_q + WIDX_W'(1);
        end
        buf_d = buf_rem;
        h_d   = h_rem;
        if (accept) begin
          buf_d      = buf_rem | (48'(pix_data) << {h_rem, 3'b000});
          h_d        = h_rem + 3'd3;
          pix_left_d = pix_left_q - PIX_W'(1);
        end
        if (pix_left_q == '0 && h_q == '0) begin
          state_d = S_POLL;
          wait_d  = '0;
        end
      end
      S_POLL: begin
        // Sequence per poll: idle interval, read strobe, then sample with address held.
        if (sample_q) begin
          wait_d = '0;
          if (axi_rd_data[0]) begin
            state_d = S_READ;
          end else if (poll_q == POLL_MAX) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else begin
            poll_d = poll_q + POLL_W'(1);
          end
        end else if (!rd_en_q) begin
          if (wait_q == POLL_LAST) begin
            rd_en_d   = 1'b1;
            rd_addr_d = ADDR_OVALID;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      S_READ: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = acc_q + OUT_W'(1);
          if (acc_q == NOUT_LAST) state_d = S_DONE;
        end
        if (sample_q) begin
          out_data_d  = axi_rd_data;
          out_valid_d = 1'b1;
        end
        // One read in flight at a time, so the word always lands in a free register.
        if (!rd_en_q && !sample_q && rd_idx_q != NOUT_C && (!out_valid_q || out_ready)) begin
          rd_en_d   = 1'b1;
          rd_addr_d = ADDR_OUTPUT + AXI_ADDR_WIDTH'({rd_idx_q, 2'b00});
          rd_idx_d  = rd_idx_q + OUT_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      error_q     <= 1'b0;
      buf_q       <= '0;
      h_q         <= '0;
      pix_left_q  <= '0;
      word_idx_q  <= '0;
      wait_q      <= '0;
      poll_q      <= '0;
      sample_q    <= 1'b0;
      rd_idx_q    <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_strobe_q <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      error_q     <= error_d;
      buf_q       <= buf_d;
      h_q         <= h_d;
      pix_left_q  <= pix_left_d;
      word_idx_q  <= word_idx_d;
      wait_q      <= wait_d;
      poll_q      <= poll_d;
      sample_q    <= sample_d;
      rd_idx_q    <= rd_idx_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_strobe_q <= wr_strobe_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

endmodule

// File: tb/tb_accel_bus_master.sv
// Directed bench for accel_bus_master on an 8x2 input frame and 8x2 output map,
// with a small accelerator bus model answering status and output-region reads.
module tb_accel_bus_master;

  localparam int NPIX      = 16;
  localparam int A_OUTPUT  = 393216;
  localparam int A_OVALID  = 395264;
  localparam int A_RESET   = 395272;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        soft_reset_en = 1'b0;
  logic [23:0] pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy, done, error;
  logic [31:0] axi_wr_data;
  logic [19:0] axi_wr_addr;
  logic        axi_wr_en;
  logic [3:0]  axi_wr_strobe;
  logic [19:0] axi_rd_addr;
  logic        axi_rd_en;
  logic [31:0] axi_rd_data = '0;

  accel_bus_master #(
    .IN_WIDTH(8), .IN_HEIGHT(2), .OUT_WIDTH(8), .OUT_HEIGHT(2),
    .AXI_ADDR_WIDTH(20), .OFFSET_OUTPUT(A_OUTPUT), .OFFSET_OVALID(A_OVALID),
    .OFFSET_RESET(A_RESET), .POLL_INTERVAL(16), .TIMEOUT_POLLS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .soft_reset_en(soft_reset_en),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .error(error),
    .axi_wr_data(axi_wr_data), .axi_wr_addr(axi_wr_addr), .axi_wr_en(axi_wr_en),
    .axi_wr_strobe(axi_wr_strobe), .axi_rd_addr(axi_rd_addr), .axi_rd_en(axi_rd_en),
    .axi_rd_data(axi_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic [19:0] addr;
    logic [31:0] data;
    logic [3:0]  strobe;
  } wr_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [19:0] addr;
  } rd_t;

  wr_t         wrq[$];
  rd_t         rdq[$];
  logic [31:0] outq[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int pix_idx, accept_cnt, both_cnt, hold_err, stall_err;
  int done_cnt, done_cyc, last_acc_cyc;
  int ovalid_zeros, ovalid_polls;
  bit ready_toggle = 1'b0;
  bit rd_next_v = 1'b0, prev_rd_en = 1'b0, prev_stall = 1'b0;
  logic [31:0] rd_next = '0, prev_out = '0;
  logic [19:0] prev_rd_addr = '0;

  // Bus model answers a read on the cycle after axi_rd_en; status reads report
  // not-ready (bit0 low, other bits set) until ovalid_zeros polls have been seen.
  task automatic tick(input bit st, input bit sr);
    wr_t e;
    rd_t r;
    @(negedge clk);
    cyc++;
    axi_rd_data = rd_next_v ? rd_next : 32'hDEADBEEF;
    rd_next_v = 1'b0;
    start = st;
    soft_reset_en = sr;
    if (pix_idx < NPIX) begin
      pix_valid = 1'b1;
      pix_data = {8'(3 * pix_idx + 3), 8'(3 * pix_idx + 2), 8'(3 * pix_idx + 1)};
    end else begin
      pix_valid = 1'b0;
      pix_data = '0;
    end
    out_ready = ready_toggle ? cyc[0] : 1'b1;
    #1;
    if (pix_valid && pix_ready) begin
      pix_idx++;
      accept_cnt++;
    end
    if (axi_wr_en) begin
      e.cyc = cyc; e.addr = axi_wr_addr; e.data = axi_wr_data; e.strobe = axi_wr_strobe;
      wrq.push_back(e);
    end
    if (axi_wr_en && axi_rd_en) both_cnt++;
    if (prev_rd_en && axi_rd_addr !== prev_rd_addr) hold_err++;
    if (axi_rd_en) begin
      r.cyc = cyc; r.addr = axi_rd_addr;
      rdq.push_back(r);
      rd_next_v = 1'b1;
      if (axi_rd_addr == 20'(A_OVALID)) begin
        ovalid_polls++;
        rd_next = (ovalid_polls > ovalid_zeros) ? 32'h0000_0001 : 32'hFFFF_FFFE;
      end else begin
        rd_next = 32'hC0DE0000 | 32'(axi_rd_addr - 20'(A_OUTPUT));
      end
    end
    prev_rd_en = axi_rd_en;
    prev_rd_addr = axi_rd_addr;
    if (prev_stall && (!out_valid || out_data !== prev_out)) stall_err++;
    prev_stall = out_valid && !out_ready;
    prev_out = out_data;
    if (out_valid && out_ready) begin
      outq.push_back(out_data);
      last_acc_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic clear_logs();
    wrq.delete(); rdq.delete(); outq.delete();
    pix_idx = 0; accept_cnt = 0; both_cnt = 0; hold_err = 0; stall_err = 0;
    done_cnt = 0; done_cyc = 0; last_acc_cyc = 0; ovalid_polls = 0;
  endtask

  task automatic run_frame(input bit sr, input int budget, output bit finished);
    clear_logs();
    finished = 1'b0;
    tick(1'b1, sr);
    for (int i = 0; i < budget; i++) begin
      tick(1'b0, 1'b0);
      if (done_cnt != 0) begin
        finished = 1'b1;
        break;
      end
    end
    repeat (3) tick(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({busy, done, error, pix_ready, out_valid, axi_wr_en, axi_rd_en} !== 7'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_flags: got %b, expected 0000000",
               {busy, done, error, pix_ready, out_valid, axi_wr_en, axi_rd_en});
    end
    n_cmp++;
    if ({axi_wr_addr, axi_wr_data, axi_wr_strobe, axi_rd_addr} !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_bus: got wa=%0h wd=%0h ws=%0h ra=%0h, expected all 0",
               axi_wr_addr, axi_wr_data, axi_wr_strobe, axi_rd_addr);
    end
    n_cmp++;
    if (out_data !== 32'h0) begin
      n_bad++;
      $display("[TB] FAIL reset_out_data: got %0h, expected 0", out_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_pack_frame();
    bit ok;
    int bad;
    ovalid_zeros = 0;
    ready_toggle = 1'b0;
    run_frame(1'b0, 600, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("[TB] FAIL pack_finish: got no done, expected done"); end
    n_cmp++;
    if (wrq.size() != 12) begin
      n_bad++; $display("[TB] FAIL pack_wr_count: got %0d, expected 12", wrq.size());
    end
    n_cmp++;
    if (wrq[0].addr !== 20'd0 || wrq[0].data !== 32'h04030201) begin
      n_bad++; $display("[TB] FAIL pack_wr0: got %0h@%0h, expected 04030201@0", wrq[0].data, wrq[0].addr);
    end
    n_cmp++;
    if (wrq[1].addr !== 20'd4 || wrq[1].data !== 32'h08070605) begin
      n_bad++; $display("[TB] FAIL pack_wr1: got %0h@%0h, expected 08070605@4", wrq[1].data, wrq[1].addr);
    end
    n_cmp++;
    if (wrq[11].addr !== 20'd44 || wrq[11].data !== 32'h302F2E2D) begin
      n_bad++; $display("[TB] FAIL pack_wr11: got %0h@%0h, expected 302f2e2d@2c", wrq[11].data, wrq[11].addr);
    end
    bad = 0;
    foreach (wrq[i]) if (wrq[i].addr !== 20'(4 * i) || wrq[i].strobe !== 4'hF) bad++;
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("[TB] FAIL pack_addr_seq: got %0d bad writes, expected 0", bad); end
    n_cmp++;
    if (accept_cnt != NPIX) begin
      n_bad++; $display("[TB] FAIL pack_accepts: got %0d, expected %0d", accept_cnt, NPIX);
    end
    n_cmp++;
    if (both_cnt != 0) begin n_bad++; $display("[TB] FAIL pack_rd_wr_overlap: got %0d, expected 0", both_cnt); end
    n_cmp++;
    if (outq.size() != 4 || outq[0] !== 32'hC0DE0000 || outq[3] !== 32'hC0DE000C) begin
      n_bad++; $display("[TB] FAIL pack_out: got n=%0d first=%0h last=%0h, expected 4 c0de0000 c0de000c",
                        outq.size(), outq[0], outq[3]);
    end
    n_cmp++;
    if (done_cnt != 1 || busy !== 1'b0 || error !== 1'b0) begin
      n_bad++; $display("[TB] FAIL pack_end: got done=%0d busy=%b err=%b, expected 1 0 0", done_cnt, busy, error);
    end
  endtask

  task automatic test_soft_reset();
    bit ok;
    ovalid_zeros = 0;
    ready_toggle = 1'b0;
    run_frame(1'b1, 600, ok);
    n_cmp++;
    if (!ok || wrq.size() != 13) begin
      n_bad++; $display("[TB] FAIL srst_wr_count: got done=%b n=%0d, expected 1 13", ok, wrq.size());
    end
    n_cmp++;
    if (wrq[0].addr !== 20'(A_RESET) || wrq[0].data !== 32'h1 || wrq[0].strobe !== 4'h1) begin
      n_bad++; $display("[TB] FAIL srst_first_write: got %0h@%0d s=%0h, expected 1@%0d s=1",
                        wrq[0].data, wrq[0].addr, wrq[0].strobe, A_RESET);
    end
    n_cmp++;
    if (rdq.size() == 0 || rdq[0].cyc <= wrq[0].cyc) begin
      n_bad++; $display("[TB] FAIL srst_first_op: got read cycle %0d vs write cycle %0d, expected read later",
                        rdq[0].cyc, wrq[0].cyc);
    end
    n_cmp++;
    if (int'(wrq[1].cyc) - int'(wrq[0].cyc) < 17) begin
      n_bad++; $display("[TB] FAIL srst_gap: got %0d cycles, expected >= 17", int'(wrq[1].cyc) - int'(wrq[0].cyc));
    end
    n_cmp++;
    if (wrq[1].addr !== 20'd0 || wrq[1].data !== 32'h04030201) begin
      n_bad++; $display("[TB] FAIL srst_pixel_wr: got %0h@%0h, expected 04030201@0", wrq[1].data, wrq[1].addr);
    end
  endtask

  task automatic test_poll();
    bit ok;
    int polls, gap_bad, last_poll_cyc, first_out_idx, out_bad, n_out;
    ovalid_zeros = 3;
    ready_toggle = 1'b0;
    run_frame(1'b0, 600, ok);
    polls = 0; gap_bad = 0; last_poll_cyc = 0; first_out_idx = -1; out_bad = 0; n_out = 0;
    foreach (rdq[i]) begin
      if (rdq[i].addr == 20'(A_OVALID)) begin
        if (polls > 0 && int'(rdq[i].cyc) - last_poll_cyc != 18) gap_bad++;
        last_poll_cyc = rdq[i].cyc;
        polls++;
      end else begin
        if (first_out_idx < 0) first_out_idx = i;
        if (rdq[i].addr !== 20'(A_OUTPUT + 4 * n_out) || int'(rdq[i].cyc) < last_poll_cyc) out_bad++;
        n_out++;
      end
    end
    n_cmp++;
    if (!ok || polls != 4) begin n_bad++; $display("[TB] FAIL poll_count: got %0d, expected 4", polls); end
    n_cmp++;
    if (gap_bad != 0) begin n_bad++; $display("[TB] FAIL poll_spacing: got %0d bad gaps, expected 0", gap_bad); end
    n_cmp++;
    if (first_out_idx != 4) begin
      n_bad++; $display("[TB] FAIL poll_then_read: got first output read at index %0d, expected 4", first_out_idx);
    end
    n_cmp++;
    if (n_out != 4 || out_bad != 0) begin
      n_bad++; $display("[TB] FAIL poll_out_reads: got n=%0d bad=%0d, expected 4 0", n_out, out_bad);
    end
    n_cmp++;
    if (hold_err != 0) begin n_bad++; $display("[TB] FAIL poll_addr_hold: got %0d, expected 0", hold_err); end
  endtask

  task automatic test_read_backpressure();
    bit ok;
    int bad;
    ovalid_zeros = 0;
    ready_toggle = 1'b1;
    run_frame(1'b0, 600, ok);
    ready_toggle = 1'b0;
    bad = 0;
    foreach (outq[i]) if (outq[i] !== (32'hC0DE0000 | 32'(4 * i))) bad++;
    n_cmp++;
    if (!ok || outq.size() != 4 || bad != 0) begin
      n_bad++; $display("[TB] FAIL bp_words: got n=%0d bad=%0d, expected 4 0", outq.size(), bad);
    end
    n_cmp++;
    if (stall_err != 0) begin n_bad++; $display("[TB] FAIL bp_hold: got %0d unstable stalls, expected 0", stall_err); end
    n_cmp++;
    if (done_cnt != 1 || done_cyc <= last_acc_cyc) begin
      n_bad++; $display("[TB] FAIL bp_done: got done=%0d at %0d last accept %0d, expected 1 after",
                        done_cnt, done_cyc, last_acc_cyc);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int polls, others;
    ovalid_zeros = 1000;
    ready_toggle = 1'b0;
    run_frame(1'b0, 600, ok);
    polls = 0; others = 0;
    foreach (rdq[i]) if (rdq[i].addr == 20'(A_OVALID)) polls++; else others++;
    n_cmp++;
    if (!ok || polls != 4 || others != 0) begin
      n_bad++; $display("[TB] FAIL timeout_reads: got polls=%0d out=%0d, expected 4 0", polls, others);
    end
    n_cmp++;
    if (error !== 1'b1 || done_cnt != 1 || outq.size() != 0) begin
      n_bad++; $display("[TB] FAIL timeout_flags: got err=%b done=%0d words=%0d, expected 1 1 0",
                        error, done_cnt, outq.size());
    end
    ovalid_zeros = 0;
    run_frame(1'b0, 600, ok);
    n_cmp++;
    if (!ok || error !== 1'b0 || outq.size() != 4) begin
      n_bad++; $display("[TB] FAIL error_clear: got err=%b words=%0d, expected 0 4", error, outq.size());
    end
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    ovalid_zeros = 0;
    ready_toggle = 1'b0;
    clear_logs();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, error, pix_ready, out_valid, axi_wr_en, axi_rd_en} !== 7'b0 ||
        {axi_wr_addr, axi_wr_data, axi_wr_strobe} !== '0) begin
      n_bad++; $display("[TB] FAIL midreset_outputs: got flags=%b wa=%0h wd=%0h, expected all 0",
                        {busy, done, error, pix_ready, out_valid, axi_wr_en, axi_rd_en}, axi_wr_addr, axi_wr_data);
    end
    repeat (4) tick(1'b0, 1'b0);
    n_cmp++;
    if (wrq.size() != 0) begin n_bad++; $display("[TB] FAIL midreset_no_write: got %0d writes, expected 0", wrq.size()); end
    rst_n = 1'b1;
    run_frame(1'b0, 600, ok);
    n_cmp++;
    if (!ok || wrq.size() != 12 || wrq[0].addr !== 20'd0 || wrq[0].data !== 32'h04030201) begin
      n_bad++; $display("[TB] FAIL midreset_restart: got n=%0d first=%0h@%0h, expected 12 04030201@0",
                        wrq.size(), wrq[0].data, wrq[0].addr);
    end
  endtask

  initial begin
    clear_logs();
    ovalid_zeros = 0;
    test_reset();
    test_pack_frame();
    test_soft_reset();
    test_poll();
    test_read_backpressure();
    test_timeout();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
